sample_pingpong_buffer: RTL
===========================

# sample_pingpong_buffer

Triggered, double-buffered capture store between the 12-bit sample source (XADC/neuron data path) and the VGA renderer. One bank fills with a triggered, decimated trace while the renderer reads the other bank. Banks swap only at a renderer frame boundary, so each displayed frame shows one complete, stable trace.

## Interface
Parameters:
- `ADDR_W`, 11: bank address width; `DEPTH = 2**ADDR_W` samples per bank.
- `DATA_W`, 12: sample width (unsigned).
- `DECIM`, 1: store every DECIM-th valid sample; must be ≥1.
- `TIMEOUT`, 4096: valid samples waited in ARM before a forced (auto) trigger.

Ports:
- `CLK104MHZ`  in  1: sole clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sample_in`  in  DATA_W: sample, qualified by `sample_valid`.
- `sample_valid`  in  1: one-cycle strobe per new sample.
- `trig_level`  in  DATA_W: rising-edge trigger threshold.
- `frame_done`  in  1: one-cycle pulse from the renderer at end of frame (VS).
- `sampleRequest`  in  ADDR_W: renderer read address.
- `sendSample`  out  DATA_W: read data, registered.
- `activeBRAMselect`  out  1: bank currently displayed (read bank). The write bank is always the other one.
- `capture_busy`  out  1: high while in CAPTURE.
- `auto_trig`  out  1: high when the last trace was captured via timeout.

## Operation
- States: ARM, CAPTURE, DONE. The reset state is ARM.
- `prev` register holds the last valid sample. Reset value is 0.
- ARM:
  - On each valid sample, test the trigger: `prev < trig_level && sample_in >= trig_level` (unsigned compare).
  - The timeout counter increments per valid sample. A trigger also fires when the counter reaches TIMEOUT-1 on a valid sample.
  - On trigger:
    - Write that sample to address 0 of the write bank.
    - Set `wptr` to 1 and `decim_cnt` to 0.
    - Latch `auto_trig` (1 if timeout fired without a crossing, else 0).
    - Go to CAPTURE.
  - A real crossing wins over a simultaneous timeout, so `auto_trig` = 0 in that case.
- CAPTURE:
  - On each valid sample, `decim_cnt` increments modulo DECIM.
  - When `decim_cnt == DECIM-1`, write the sample at `wptr` and increment `wptr`.
  - After the write to DEPTH-1, go to DONE.
- DONE:
  - Ignore samples.
  - On `frame_done`, toggle `activeBRAMselect`, clear the timeout counter, and go to ARM.
- `frame_done` is ignored in ARM and CAPTURE. A bank is never shown partially written.
- `prev` updates on every valid sample in every state.
- Reads and writes always target different banks, so no collision handling is needed.
- Mid-operation reset: return to ARM with bank 0 displayed and all counters cleared. RAM contents are not cleared.

## Timing
- Reset values:
  - `sendSample` = 0
  - `activeBRAMselect` = 0
  - `capture_busy` = 0
  - `auto_trig` = 0
  - `wptr`, `decim_cnt`, timeout counter = 0
- Read latency: `sendSample` reflects `sampleRequest` sampled 1 cycle earlier, from the bank selected in that same earlier cycle.
- A write occurs in the same cycle as the qualifying `sample_valid`.
- The trigger sample is written the cycle it arrives. `capture_busy` rises the next cycle.
- `frame_done` in DONE: `activeBRAMselect` toggles on the next edge. A read issued in the cycle of that edge returns data from the new bank.
- Trace length in valid samples: 1 + (DEPTH-1)·DECIM from trigger to DONE.

## Structure
- Shared package/header `spb_defs`:
  - State encoding (`ST_ARM=0`, `ST_CAPTURE=1`, `ST_DONE=2`, 2 bits).
  - Default `ADDR_W`/`DATA_W`, shared with the renderer.
- Sub-module `pingpong_bram`:
  - Two banks of DEPTH×DATA_W, one write port and one registered read port.
  - Bank-select inputs for write and read.
  - Coded to infer block RAM.
- Top of this block: FSM, trigger compare, decimation/timeout counters.

## Test plan
Bench parameters: ADDR_W=4 (DEPTH 16), DECIM=1, TIMEOUT=8, `trig_level`=100.
- Samples 50, 90, 110, then 111…125 → trigger on 110 (`auto_trig`=0). Bank 1 holds 110..125 at addresses 0..15. DONE after 16 writes; `activeBRAMselect` stays 0.
- In DONE, pulse `frame_done`; then read addresses 0..15 → `activeBRAMselect`=1 and `sendSample` = 110..125, each 1 cycle after its address.
- Constant sample 20 → forced trigger on the 8th valid sample, `auto_trig`=1. The bank holds sixteen 20s.
- DECIM=3, ramp 100,101,102,… starting from prev 0 → trigger at 100. Stored values 100,103,106,…,145.
- Pulse `frame_done` during ARM and during CAPTURE → no bank toggle and no state change.
- Assert `rst` mid-CAPTURE after 5 writes → all outputs return to reset values at once (async). The next trace starts at address 0 of bank 1.

Source files
------------

// File: rtl/sample_pingpong_buffer_pkg.sv
// Shared definitions for the triggered ping-pong capture store: FSM state
// encoding and the default widths also used by the VGA renderer.
package spb_defs;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } spbState_t;

  localparam int SPB_ADDR_W = 11;
  localparam int SPB_DATA_W = 12;

endpackage

// File: rtl/sample_pingpong_buffer_bram.sv
// Two-bank sample memory: one synchronous write port and one registered read
// port, each with its own bank select. Coded as a single array for BRAM inference.
module pingpong_bram
  import spb_defs::*;
#(
  parameter int ADDR_W = SPB_ADDR_W,
  parameter int DATA_W = SPB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wrEn,
  input  logic              i_wrBank,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdBank,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];
  logic [DATA_W-1:0] r_rdData;

  // Memory contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[{i_wrBank, i_wrAddr}] <= i_wrData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdData <= '0;
    end else begin
      r_rdData <= r_mem[{i_rdBank, i_rdAddr}];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/sample_pingpong_buffer.sv
// Triggered, decimated trace capture into one bank while the renderer reads
// the other; banks swap only on a renderer frame boundary.
module sample_pingpong_buffer
  import spb_defs::*;
#(
  parameter int ADDR_W  = SPB_ADDR_W,
  parameter int DATA_W  = SPB_DATA_W,
  parameter int DECIM   = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic              CLK104MHZ,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              frame_done,
  input  logic [ADDR_W-1:0] sampleRequest,
  output logic [DATA_W-1:0] sendSample,
  output logic              activeBRAMselect,
  output logic              capture_busy,
  output logic              auto_trig
);

  localparam int DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  spbState_t         r_state;
  logic [DATA_W-1:0] r_prev;
  logic [ADDR_W-1:0] r_wptr;
  logic [DC_W-1:0]   r_decimCnt;
  logic [TO_W-1:0]   r_toCnt;
  logic              r_activeSel;
  logic              r_busy;
  logic              r_autoTrig;

  logic              w_cross;
  logic              w_timeout;
  logic              w_trigFire;
  logic              w_decimHit;
  logic              w_wrEn;
  logic [ADDR_W-1:0] w_wrAddr;
  logic [DATA_W-1:0] w_rdData;

  assign w_cross    = (r_prev < trig_level) && (sample_in >= trig_level);
  assign w_timeout  = (r_toCnt == TO_W'(TIMEOUT - 1));
  assign w_trigFire = w_cross || w_timeout;
  assign w_decimHit = (r_decimCnt == DC_W'(DECIM - 1));

  // The trigger sample lands at address 0; later writes follow the pointer.
  always_comb begin
    w_wrEn   = 1'b0;
    w_wrAddr = '0;
    if (sample_valid) begin
      if ((r_state == ST_ARM) && w_trigFire) begin
        w_wrEn   = 1'b1;
        w_wrAddr = '0;
      end else if ((r_state == ST_CAPTURE) && w_decimHit) begin
        w_wrEn   = 1'b1;
        w_wrAddr = r_wptr;
      end
    end
  end

  always_ff @(posedge CLK104MHZ or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ARM;
      r_prev      <= '0;
      r_wptr      <= '0;
      r_decimCnt  <= '0;
      r_toCnt     <= '0;
      r_activeSel <= 1'b0;
      r_busy      <= 1'b0;
      r_autoTrig  <= 1'b0;
    end else begin
      if (sample_valid) begin
        r_prev <= sample_in;
      end
      case (r_state)
        ST_ARM: begin
          if (sample_valid) begin
            if (w_trigFire) begin
              r_wptr     <= ADDR_W'(1);
              r_decimCnt <= '0;
              r_autoTrig <= ~w_cross;
              r_busy     <= 1'b1;
              r_state    <= ST_CAPTURE;
            end else begin
              r_toCnt <= r_toCnt + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (sample_valid) begin
            if (w_decimHit) begin
              r_decimCnt <= '0;
              r_wptr     <= r_wptr + 1'b1;
              // The last address of the bank has just been written.
              if (r_wptr == '1) begin
                r_busy  <= 1'b0;
                r_state <= ST_DONE;
              end
            end else begin
              r_decimCnt <= r_decimCnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (frame_done) begin
            r_activeSel <= ~r_activeSel;
            r_toCnt     <= '0;
            r_state     <= ST_ARM;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_ARM;
        end
      endcase
    end
  end

  pingpong_bram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_bram (
    .clk     (CLK104MHZ),
    .rst     (rst),
    .i_wrEn  (w_wrEn),
    .i_wrBank(~r_activeSel),
    .i_wrAddr(w_wrAddr),
    .i_wrData(sample_in),
    .i_rdBank(r_activeSel),
    .i_rdAddr(sampleRequest),
    .o_rdData(w_rdData)
  );

  assign sendSample       = w_rdData;
  assign activeBRAMselect = r_activeSel;
  assign capture_busy     = r_busy;
  assign auto_trig        = r_autoTrig;

endmodule
